ad9363_rx_packer: RTL and testbench

Receive-path stage directly downstream of the AD9363 CMOS interface. It consumes 12-bit I/Q samples (adc_valid, adc_data_i1, adc_data_q1, rx_status) on user_clk and sign-extends each pair into one 32-bit word. Words are buffered in a synchronous FIFO and emitted as fixed-length AXI4-Stream packets toward the DMA. Admission is done per packet, so a full buffer drops whole packets and never truncates one.

---
 rtl/ad9363_pkg.sv | 16 +
 rtl/ad9363_rx_fifo.sv | 59 +++++
 rtl/ad9363_rx_packer.sv | 158 +++++++++++++++
 tb/tb_ad9363_rx_packer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9363_pkg.sv
// Shared widths, FSM encodings and sample formatting for the AD9363 receive packer.
package ad9363_pkg;

   localparam int unsigned ADC_W        = 12;
   localparam int unsigned AXIS_W       = 32;
   localparam int unsigned SAMPLE_EXT_W = 16;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] DROP  = 2'd2;

   function automatic logic [SAMPLE_EXT_W-1:0] sext(input logic [ADC_W-1:0] x);
      return {{(SAMPLE_EXT_W-ADC_W){x[ADC_W-1]}}, x};
   endfunction

endpackage

// File: rtl/ad9363_rx_fifo.sv
// Synchronous FIFO with a registered show-ahead read port.
// occupancy_c counts stored words including the one held in the output register.
module ad9363_rx_fifo
   import ad9363_pkg::*;
#(
   parameter int unsigned WIDTH = AXIS_W + 1,
   parameter int unsigned AW    = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [AW:0]      occupancy_c,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   input  logic             rd_ready
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned CW    = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      mem_cnt;
   logic             pop;

   // Refill the output register whenever it is empty or being consumed.
   assign pop         = (mem_cnt != '0) && (!rd_valid || rd_ready);
   assign occupancy_c = mem_cnt + CW'(rd_valid);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + AW'(1);
            rd_data  <= mem[rd_ptr];
            rd_valid <= 1'b1;
         end else if (rd_ready) begin
            rd_valid <= 1'b0;
         end
         mem_cnt <= mem_cnt + CW'(wr_en) - CW'(pop);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(wr_en && (mem_cnt == CW'(DEPTH))));

endmodule

// File: rtl/ad9363_rx_packer.sv
// AD9363 receive packer: sign-extends I/Q pairs and emits fixed-length AXIS packets,
// admitting a packet only when the FIFO can hold all of it.
module ad9363_rx_packer
   import ad9363_pkg::*;
#(
   parameter int unsigned PKT_LEN = 256,
   parameter int unsigned FIFO_AW = 9,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              user_clk,
   input  logic              rst,
   input  logic              adc_valid,
   input  logic [ADC_W-1:0]  adc_data_i1,
   input  logic [ADC_W-1:0]  adc_data_q1,
   input  logic              rx_status,
   input  logic              capture_en,
   output logic [AXIS_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              overflow,
   input  logic              overflow_clr,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam int unsigned DEPTH  = 2 ** FIFO_AW;
   localparam int unsigned IDX_W  = $clog2(PKT_LEN);
   localparam int unsigned SUM_W  = FIFO_AW + 2;
   localparam int unsigned FIFO_W = AXIS_W + 1;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_nxt;
   logic              take;
   logic              last;
   logic              drop;
   logic              done;
   logic              idx_last;
   logic              qual;
   logic              admit;
   logic [SUM_W-1:0]  used;
   logic [FIFO_AW:0]  occ;
   logic              s_valid;
   logic              s_last;
   logic [AXIS_W-1:0] s_data;
   logic [FIFO_W-1:0] fifo_rd;

   // Space check counts the sample still sitting in the input register.
   assign used     = SUM_W'(occ) + SUM_W'(s_valid);
   assign admit    = (used + SUM_W'(PKT_LEN)) <= SUM_W'(DEPTH);
   assign qual     = adc_valid & capture_en & rx_status;
   assign idx_last = (idx == IDX_W'(PKT_LEN - 1));

   always_ff @(posedge user_clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      take      = 1'b0;
      last      = 1'b0;
      drop      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (qual) begin
               idx_nxt = IDX_W'(1);
               if (admit) begin
                  take      = 1'b1;
                  state_nxt = WRITE;
               end else begin
                  drop      = 1'b1;
                  state_nxt = DROP;
               end
            end
         end
         WRITE: begin
            if (adc_valid) begin
               take = 1'b1;
               last = idx_last;
               if (idx_last) begin
                  done      = 1'b1;
                  idx_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         DROP: begin
            if (adc_valid) begin
               if (idx_last) begin
                  idx_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         default: begin
            idx_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Input register, counters and sticky overflow; a new drop beats a clear.
   always_ff @(posedge user_clk or posedge rst) begin
      if (rst) begin
         s_valid  <= 1'b0;
         s_last   <= 1'b0;
         s_data   <= '0;
         pkt_cnt  <= '0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         s_valid <= take;
         if (take) begin
            s_data <= {sext(adc_data_q1), sext(adc_data_i1)};
            s_last <= last;
         end
         if (done) pkt_cnt <= pkt_cnt + CNT_W'(1);
         if (drop) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   ad9363_rx_fifo #(
      .WIDTH (FIFO_W),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk         (user_clk),
      .rst         (rst),
      .wr_en       (s_valid),
      .wr_data     ({s_last, s_data}),
      .occupancy_c (occ),
      .rd_valid    (m_axis_tvalid),
      .rd_data     (fifo_rd),
      .rd_ready    (m_axis_tready)
   );

   assign m_axis_tdata = fifo_rd[AXIS_W-1:0];
   assign m_axis_tlast = fifo_rd[AXIS_W];

endmodule

// File: tb/tb_ad9363_rx_packer.sv
// Scoreboard bench for ad9363_rx_packer with PKT_LEN=4 and an 8-deep FIFO.
module tb_ad9363_rx_packer;

   localparam int unsigned PKT_LEN = 4;
   localparam int unsigned FIFO_AW = 3;
   localparam int unsigned CNT_W   = 16;

   logic             user_clk = 1'b0;
   logic             rst = 1'b1;
   logic             adc_valid = 1'b0;
   logic [11:0]      adc_data_i1 = '0;
   logic [11:0]      adc_data_q1 = '0;
   logic             rx_status = 1'b0;
   logic             capture_en = 1'b0;
   logic             m_axis_tready = 1'b0;
   logic             overflow_clr = 1'b0;
   logic [31:0]      m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tlast;
   logic             overflow;
   logic [CNT_W-1:0] pkt_cnt;
   logic [CNT_W-1:0] drop_cnt;

   logic [32:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          n_words = 0;
   bit          toggle_rdy = 1'b0;
   bit          stall = 1'b0;
   logic [32:0] held = '0;
   logic [32:0] exp1 [4] = '{33'h0_FFFF0001, 33'h0_FFFE0002, 33'h0_FFFD0003, 33'h1_FFFC0004};

   ad9363_rx_packer #(
      .PKT_LEN (PKT_LEN),
      .FIFO_AW (FIFO_AW),
      .CNT_W   (CNT_W)
   ) dut (
      .user_clk      (user_clk),
      .rst           (rst),
      .adc_valid     (adc_valid),
      .adc_data_i1   (adc_data_i1),
      .adc_data_q1   (adc_data_q1),
      .rx_status     (rx_status),
      .capture_en    (capture_en),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .overflow      (overflow),
      .overflow_clr  (overflow_clr),
      .pkt_cnt       (pkt_cnt),
      .drop_cnt      (drop_cnt)
   );

   always #5 user_clk = ~user_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [32:0] fmt(input bit lst, input logic [11:0] i, input logic [11:0] q);
      return {lst, {4{q[11]}}, q, {4{i[11]}}, i};
   endfunction

   task automatic drive(input bit v, input logic [11:0] i, input logic [11:0] q);
      adc_valid   = v;
      adc_data_i1 = i;
      adc_data_q1 = q;
      @(posedge user_clk);
      #1;
      adc_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge user_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      idle(2);
      rst = 1'b0;
      idle(1);
   endtask

   task automatic drain(input string name, input int max);
      int n = 0;
      while ((exp_q.size() != 0 || m_axis_tvalid) && n < max) begin
         idle(1);
         n++;
      end
      check(name, 64'((exp_q.size() == 0) && !m_axis_tvalid), 64'd1);
   endtask

   // Monitor: pops on every handshake, and checks that stalled outputs hold.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge user_clk);
         if (rst) begin
            stall = 1'b0;
         end else begin
            if (stall) check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held});
            if (m_axis_tvalid && m_axis_tready) begin
               n_words++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_word: got 0x%0h with nothing expected", {m_axis_tlast, m_axis_tdata});
               end else begin
                  e = exp_q.pop_front();
                  check("word", {m_axis_tlast, m_axis_tdata}, e);
               end
            end
            stall = m_axis_tvalid && !m_axis_tready;
            held  = {m_axis_tlast, m_axis_tdata};
         end
      end
   end

   initial begin
      forever begin
         @(posedge user_clk);
         #2;
         if (toggle_rdy) m_axis_tready = ~m_axis_tready;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;

      // Test 1: basic packet, latency, reset state
      do_reset();
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      capture_en = 1'b1;
      rx_status = 1'b1;
      m_axis_tready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(exp1[k]);
         drive(1'b1, 12'(k + 1), 12'(12'hFFF - k));
         if (k == 1) check("lat_tvalid_early", 64'(m_axis_tvalid), 64'd0);
         if (k == 2) check("lat_tvalid", 64'(m_axis_tvalid), 64'd1);
      end
      drain("t1_drain", 50);
      check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
      check("t1_drop_cnt", 64'(drop_cnt), 64'd0);

      // Test 2: tready toggling every cycle
      do_reset();
      toggle_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(exp1[k]);
         drive(1'b1, 12'(k + 1), 12'(12'hFFF - k));
      end
      drain("t2_drain", 50);
      toggle_rdy = 1'b0;
      idle(1);
      m_axis_tready = 1'b1;
      check("t2_pkt_cnt", 64'(pkt_cnt), 64'd1);

      // Test 3: backpressure fills FIFO, third packet dropped whole
      do_reset();
      m_axis_tready = 1'b0;
      for (int n = 0; n < 12; n++) begin
         if (n < 8) exp_q.push_back(fmt(n % 4 == 3, 12'(12'h100 + n), 12'(12'h800 + n)));
         drive(1'b1, 12'(12'h100 + n), 12'(12'h800 + n));
      end
      idle(3);
      check("t3_overflow", 64'(overflow), 64'd1);
      check("t3_drop_cnt", 64'(drop_cnt), 64'd1);
      check("t3_pkt_cnt", 64'(pkt_cnt), 64'd2);
      w0 = n_words;
      m_axis_tready = 1'b1;
      drain("t3_drain", 100);
      idle(3);
      check("t3_word_count", 64'(n_words - w0), 64'd8);
      overflow_clr = 1'b1;
      idle(1);
      overflow_clr = 1'b0;
      check("t3_overflow_clr", 64'(overflow), 64'd0);

      // Test 4: capture_en falls mid-packet
      do_reset();
      capture_en = 1'b1;
      w0 = n_words;
      for (int n = 0; n < 10; n++) begin
         if (n == 2) capture_en = 1'b0;
         if (n < 4) exp_q.push_back(fmt(n == 3, 12'(12'h7F0 + n), 12'(12'h00A + n)));
         drive(1'b1, 12'(12'h7F0 + n), 12'(12'h00A + n));
      end
      idle(5);
      drain("t4_drain", 50);
      check("t4_pkt_cnt", 64'(pkt_cnt), 64'd1);
      check("t4_word_count", 64'(n_words - w0), 64'd4);
      capture_en = 1'b1;

      // Test 5: rx_status low blocks capture
      do_reset();
      rx_status = 1'b0;
      for (int n = 0; n < 4; n++) drive(1'b1, 12'(n), 12'(n));
      idle(4);
      check("t5_no_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("t5_pkt_cnt0", 64'(pkt_cnt), 64'd0);
      rx_status = 1'b1;
      for (int n = 0; n < 4; n++) begin
         exp_q.push_back(fmt(n == 3, 12'(12'hA50 + n), 12'(12'h3C0 + n)));
         drive(1'b1, 12'(12'hA50 + n), 12'(12'h3C0 + n));
      end
      drain("t5_drain", 50);
      check("t5_pkt_cnt", 64'(pkt_cnt), 64'd1);

      // Test 6: reset mid-packet while output is active
      do_reset();
      for (int n = 0; n < 4; n++) begin
         exp_q.push_back(fmt(n == 3, 12'(12'h050 + n), 12'(12'hF00 + n)));
         drive(1'b1, 12'(12'h050 + n), 12'(12'hF00 + n));
      end
      drive(1'b1, 12'h111, 12'h222);
      drive(1'b1, 12'h333, 12'h444);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("t6_rst_tlast", 64'(m_axis_tlast), 64'd0);
      check("t6_rst_tdata", 64'(m_axis_tdata), 64'd0);
      check("t6_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      check("t6_rst_drop_cnt", 64'(drop_cnt), 64'd0);
      check("t6_rst_overflow", 64'(overflow), 64'd0);
      idle(2);
      rst = 1'b0;
      idle(1);
      for (int n = 0; n < 4; n++) begin
         exp_q.push_back(fmt(n == 3, 12'(12'h801 + n), 12'(12'h7FE - n)));
         drive(1'b1, 12'(12'h801 + n), 12'(12'h7FE - n));
      end
      drain("t6_drain", 50);
      check("t6_pkt_cnt", 64'(pkt_cnt), 64'd1);

      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
